seg7_scan_driver: RTL

Parametrised, time-multiplexed driver for a bank of common-anode/common-cathode 7-segment digits. It accepts a packed hexadecimal word and per-digit decimal-point bits, double-buffers them so updates never tear mid-frame, and scans the digits one at a time. Each digit slot has a programmable anti-ghosting blank window. It sits between the CPU's output/register file and the board display pins, replacing per-digit static hex decoders.

---
 rtl/seg7_pkg.sv | 13 +
 rtl/seg7_hex_lut.sv | 13 +
 rtl/seg7_scan_driver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: logical segment codes {g,f,e,d,c,b,a} with lit = 1.
package seg7_pkg;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG7_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex nibble to logical (active-high) 7-segment code.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner with double-buffered display data,
// leading-zero blanking and a per-slot anti-ghosting blank window.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic                  blank_lz_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [DIG_W-1:0]      dig_idx_q, dig_idx_d;
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic                  wrap_q, wrap_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  div_wrap, frame_wrap;
  logic [3:0]            nib [DIGITS];
  logic [DIGITS-1:0]     lz_zero;
  logic [3:0]            nib_sel;
  logic [6:0]            lut_seg;
  logic                  run_zero;
  logic                  blank_win, blank_dig;
  logic [6:0]            seg_log;
  logic                  dp_log;
  logic [DIGITS-1:0]     an_log;

  seg7_hex_lut u_lut (
    .nibble_i (nib_sel),
    .seg_o    (lut_seg)
  );

  // Counters and double buffer
  always_comb begin
    div_wrap     = (div_cnt_q == DIV_LAST);
    frame_wrap   = div_wrap && (dig_idx_q == DIG_LAST);
    div_cnt_d    = div_wrap ? '0 : div_cnt_q + 1'b1;
    dig_idx_d    = dig_idx_q;
    if (div_wrap) begin
      dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + 1'b1;
    end
    wrap_d       = frame_wrap;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (load_i) begin
      shadow_val_d = value_i;
      shadow_dp_d  = dp_i;
      pending_d    = 1'b1;
    end
    // A load on the boundary cycle bypasses the shadow and lands in this frame.
    if (frame_wrap) begin
      if (load_i) begin
        disp_val_d = value_i;
        disp_dp_d  = dp_i;
      end else if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_dp_d  = shadow_dp_q;
      end
      pending_d = 1'b0;
    end
  end

  // Digit selection, blanking and output encoding
  always_comb begin
    run_zero = 1'b1;
    lz_zero  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib[k]     = disp_val_q[4*k +: 4];
      run_zero   = run_zero && (nib[k] == 4'h0);
      lz_zero[k] = run_zero;
    end
    nib_sel   = nib[dig_idx_q];
    blank_win = (div_cnt_q < BLANK_C);
    blank_dig = blank_lz_i && (dig_idx_q != '0) && lz_zero[dig_idx_q];
    an_log    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      an_log[k] = (dig_idx_q == DIG_W'(k));
    end
    seg_log   = blank_dig ? 7'h00 : lut_seg;
    dp_log    = disp_dp_q[dig_idx_q];
    if (blank_win) begin
      an_log  = '0;
      seg_log = 7'h00;
      dp_log  = 1'b0;
    end
    seg_d   = seg_log ^ {7{POL}};
    dp_d    = dp_log ^ POL;
    an_d    = an_log ^ {DIGITS{POL}};
    frame_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      dig_idx_q    <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      wrap_q       <= 1'b0;
      seg_q        <= {7{POL}};
      dp_q         <= POL;
      an_q         <= {DIGITS{POL}};
      frame_q      <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      dig_idx_q    <= dig_idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule
